// File: rtl/vram_pkg.sv
// Shared VRAM write-path definitions: default widths, the queue entry layout
// and the occupancy-counter width helper.
package vram_pkg;

   localparam int VRAM_ADDR_W = 16;
   localparam int VRAM_DATA_W = 16;

   typedef struct packed {
      logic [VRAM_ADDR_W-1:0] address;
      logic [VRAM_DATA_W-1:0] data;
   } vram_wr_entry_t;

   // The counter has to represent 0..DEPTH inclusive, so it needs one extra bit.
   function automatic int fifo_count_w(input int depth_log2);
      return depth_log2 + 1;
   endfunction

endpackage

// File: rtl/vram_queue_mem.sv
// Entry storage for the VRAM write queue: flop array, one synchronous write
// port and one asynchronous read port. Kept separate so a macro can replace it.
module vram_queue_mem #(
   parameter int DEPTH_LOG2 = 5,
   parameter int WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_idx,
   input  logic [WIDTH-1:0]      wr_entry,
   input  logic [DEPTH_LOG2-1:0] rd_idx,
   output logic [WIDTH-1:0]      rd_entry
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   // Storage is deliberately not reset; the head is only meaningful when non-empty.
   logic [WIDTH-1:0] mem_q [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= wr_entry;
   end

   assign rd_entry = mem_q[rd_idx];

endmodule

// File: rtl/vram_write_queue.sv
// Write-posting FIFO between the CPU VRAM write port and the VRAM arbiter.
// Optional write coalescing into the newest entry: define VRAM_FIFO_COALESCE_EN.
module vram_write_queue
   import vram_pkg::*;
#(
   parameter int DATA_WIDTH        = VRAM_DATA_W,
   parameter int ADDRESS_WIDTH     = VRAM_ADDR_W,
   parameter int DEPTH_LOG2        = 5,
   parameter int ALMOST_FULL_LEVEL = (1 << DEPTH_LOG2) - 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [ADDRESS_WIDTH-1:0] wr_address,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [ADDRESS_WIDTH-1:0] rd_address,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic [DEPTH_LOG2:0]      items_count,
   output logic                     almost_full,
   output logic                     full,
   output logic                     empty,
   output logic                     overrun,
   output logic                     underrun,
   input  logic                     clear_errors
);

   localparam int DEPTH   = 1 << DEPTH_LOG2;
   localparam int PTR_W   = DEPTH_LOG2;
   localparam int CNT_W   = fifo_count_w(DEPTH_LOG2);
   localparam int ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH;

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] address;
      logic [DATA_WIDTH-1:0]    data;
   } entry_t;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overrun_q, overrun_d;
   logic             underrun_q, underrun_d;

   logic             push, pop, mem_we;
   logic [PTR_W-1:0] mem_idx;
   entry_t           wr_entry, head;

   assign empty       = (count_q == '0);
   assign full        = (count_q == CNT_W'(DEPTH));
   assign almost_full = (count_q >= CNT_W'(ALMOST_FULL_LEVEL));
   assign items_count = count_q;
   assign rd_valid    = !empty;
   assign overrun     = overrun_q;
   assign underrun    = underrun_q;
   assign pop         = rd_valid & rd_ready;
   assign wr_entry    = '{address: wr_address, data: wr_data};
   assign rd_address  = head.address;
   assign rd_data     = head.data;

`ifdef VRAM_FIFO_COALESCE_EN
   // Address of the newest entry; coalesced writes never change it.
   logic [ADDRESS_WIDTH-1:0] last_addr_q, last_addr_d;
   logic                     coalesce;

   // A newest entry that is being popped as the sole occupant cannot be merged into.
   assign coalesce = wr_valid & !empty & (wr_address == last_addr_q) &
                     ((count_q > CNT_W'(1)) | !pop);
   assign wr_ready = !full | rd_ready | coalesce;
   assign push     = wr_valid & wr_ready & !coalesce;
   assign mem_we   = push | coalesce;
   assign mem_idx  = coalesce ? (wr_ptr_q - PTR_W'(1)) : wr_ptr_q;

   always_comb begin
      last_addr_d = last_addr_q;
      if (push) last_addr_d = wr_address;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) last_addr_q <= '0;
      else          last_addr_q <= last_addr_d;
   end
`else
   assign wr_ready = !full | rd_ready;
   assign push     = wr_valid & wr_ready;
   assign mem_we   = push;
   assign mem_idx  = wr_ptr_q;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      // A new error event outranks a coincident clear.
      overrun_d  = (wr_valid & !wr_ready) | (overrun_q & !clear_errors);
      underrun_d = (rd_ready & empty) | (underrun_q & !clear_errors);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overrun_q  <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overrun_q  <= overrun_d;
         underrun_q <= underrun_d;
      end
   end

   vram_queue_mem #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (ENTRY_W)
   ) u_mem (
      .clk      (clk),
      .wr_en    (mem_we),
      .wr_idx   (mem_idx),
      .wr_entry (wr_entry),
      .rd_idx   (rd_ptr_q),
      .rd_entry (head)
   );

endmodule
